// File: rtl/asi_r_credit_if.sv
// AXI4 read-address and read-data channel bundle for the asi_r_credit slave.
interface asi_r_credit_if #(
    parameter int unsigned IW = 4,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64,
    parameter int unsigned LW = 8
);
    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [LW-1:0] ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;

    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/asi_r_credit.sv
// AXI4 slave read path: AR buffer, credit-gated burst expansion to a fixed-latency
// user read port, and an in-order read-data buffer feeding the R channel.
module asi_r_credit #(
    parameter int unsigned AXI_IW   = 4,
    parameter int unsigned AXI_AW   = 32,
    parameter int unsigned AXI_DW   = 64,
    parameter int unsigned AXI_LW   = 8,
    parameter int unsigned OD_DEPTH = 4,
    parameter int unsigned RD_DEPTH = 8,
    parameter int unsigned SLV_WS   = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    asi_r_credit_if.slave     axi,
    output logic [AXI_IW-1:0] m_rid,
    output logic [AXI_LW-1:0] m_rlen,
    output logic [2:0]        m_rsize,
    output logic [1:0]        m_rburst,
    output logic [AXI_AW-1:0] m_raddr,
    output logic              m_re,
    output logic              m_rlast,
    input  logic [AXI_DW-1:0] m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rslverr
);
    localparam int unsigned NB    = AXI_DW / 8;
    localparam int unsigned MAXSZ = $clog2(NB);
    localparam int unsigned ODW   = $clog2(OD_DEPTH);
    localparam int unsigned OCW   = $clog2(OD_DEPTH + 1);
    localparam int unsigned RDW   = $clog2(RD_DEPTH);
    localparam int unsigned CW    = $clog2(RD_DEPTH + 1);
    localparam int unsigned ARW   = AXI_IW + AXI_AW + AXI_LW + 5;
    localparam int unsigned RW    = AXI_IW + AXI_DW + 3;
    localparam int unsigned SW    = AXI_IW + 2;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // ---------------- AR buffer ----------------
    logic [ARW-1:0]    r_od_mem [OD_DEPTH];
    logic [ODW-1:0]    r_od_wp, r_od_rp;
    logic [OCW-1:0]    r_od_cnt;
    logic [OCW-1:0]    w_od_cnt_nxt;
    logic              r_arready;
    logic              w_ar_push, w_ar_pop;
    logic [AXI_IW-1:0] w_h_id;
    logic [AXI_AW-1:0] w_h_addr, w_h_b;
    logic [AXI_LW-1:0] w_h_len;
    logic [2:0]        w_h_size;
    logic [1:0]        w_h_burst;
    logic              w_h_len_ok, w_h_err;

    assign w_ar_push    = axi.ARVALID & r_arready;
    assign w_od_cnt_nxt = r_od_cnt + OCW'(w_ar_push) - OCW'(w_ar_pop);
    assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = r_od_mem[r_od_rp];

    always_ff @(posedge ACLK) begin
        if (w_ar_push)
            r_od_mem[r_od_wp] <= {axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_od_wp   <= '0;
            r_od_rp   <= '0;
            r_od_cnt  <= '0;
            r_arready <= 1'b1;
        end else begin
            if (w_ar_push) r_od_wp <= r_od_wp + ODW'(1);
            if (w_ar_pop)  r_od_rp <= r_od_rp + ODW'(1);
            r_od_cnt  <= w_od_cnt_nxt;
            r_arready <= (w_od_cnt_nxt != OCW'(OD_DEPTH));
        end
    end

    // Burst is flagged at pop time; errored bursts still walk INCR addresses.
    assign w_h_b      = AXI_AW'(1) << w_h_size;
    assign w_h_len_ok = (w_h_len == AXI_LW'(1)) | (w_h_len == AXI_LW'(3)) |
                        (w_h_len == AXI_LW'(7)) | (w_h_len == AXI_LW'(15));
    assign w_h_err    = (w_h_size > 3'(MAXSZ)) | (w_h_burst == 2'b11) |
                        ((w_h_burst == 2'b10) &
                         (!w_h_len_ok | ((w_h_addr & (w_h_b - AXI_AW'(1))) != '0)));

    // ---------------- burst FSM and credit ----------------
    state_t            r_state;
    logic              r_gap;
    logic              r_err;
    logic [AXI_LW-1:0] r_cnt;
    logic [CW-1:0]     r_inflight;
    logic [AXI_IW-1:0] r_m_rid;
    logic [AXI_LW-1:0] r_m_rlen;
    logic [2:0]        r_m_rsize;
    logic [1:0]        r_m_rburst;
    logic [AXI_AW-1:0] r_m_raddr;
    logic              r_m_re, r_m_rlast;
    logic              w_credit, w_beat, w_issue, w_last_beat, w_r_pop;
    logic [AXI_AW-1:0] w_b, w_wmask, w_next;

    assign w_credit    = (r_inflight < CW'(RD_DEPTH));
    assign w_ar_pop    = (r_state == S_IDLE) & !r_gap & (r_od_cnt != '0) & w_credit;
    assign w_beat      = (r_state == S_BURST) & w_credit;
    assign w_issue     = w_ar_pop | w_beat;
    assign w_last_beat = w_beat & (r_cnt == r_m_rlen);

    assign w_b     = AXI_AW'(1) << r_m_rsize;
    assign w_wmask = ((AXI_AW'(r_m_rlen) + AXI_AW'(1)) << r_m_rsize) - AXI_AW'(1);
    always_comb begin
        w_next = (r_m_raddr & ~(w_b - AXI_AW'(1))) + w_b;
        if (!r_err && r_m_rburst == 2'b00)
            w_next = r_m_raddr;
        else if (!r_err && r_m_rburst == 2'b10)
            w_next = (r_m_raddr & ~w_wmask) | ((r_m_raddr + w_b) & w_wmask);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= S_IDLE;
            r_gap      <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_inflight <= '0;
            r_m_rid    <= '0;
            r_m_rlen   <= '0;
            r_m_rsize  <= '0;
            r_m_rburst <= '0;
            r_m_raddr  <= '0;
            r_m_re     <= 1'b0;
            r_m_rlast  <= 1'b0;
        end else begin
            r_m_re     <= w_issue;
            r_m_rlast  <= 1'b0;
            r_gap      <= 1'b0;
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_r_pop);
            case (r_state)
                S_IDLE: begin
                    if (w_ar_pop) begin
                        r_m_rid    <= w_h_id;
                        r_m_rlen   <= w_h_len;
                        r_m_rsize  <= w_h_size;
                        r_m_rburst <= w_h_burst;
                        r_m_raddr  <= w_h_addr;
                        r_err      <= w_h_err;
                        r_cnt      <= AXI_LW'(1);
                        r_m_rlast  <= (w_h_len == '0);
                        if (w_h_len == '0) r_gap <= 1'b1;
                        else               r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_m_raddr <= w_next;
                        r_cnt     <= r_cnt + AXI_LW'(1);
                        if (w_last_beat) begin
                            r_m_rlast <= 1'b1;
                            r_gap     <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_rid    = r_m_rid;
    assign m_rlen   = r_m_rlen;
    assign m_rsize  = r_m_rsize;
    assign m_rburst = r_m_rburst;
    assign m_raddr  = r_m_raddr;
    assign m_re     = r_m_re;
    assign m_rlast  = r_m_rlast;

    // ---------------- side pipeline aligned to m_rvalid ----------------
    logic [SW-1:0] w_side_in, w_side_out;
    assign w_side_in = {r_m_rid, r_m_rlast, r_err};

    if (SLV_WS == 0) begin : g_nopipe
        assign w_side_out = w_side_in;
    end else begin : g_pipe
        logic [SW-1:0] r_side [SLV_WS];
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                for (int i = 0; i < int'(SLV_WS); i++) r_side[i] <= '0;
            end else begin
                r_side[0] <= w_side_in;
                for (int i = 1; i < int'(SLV_WS); i++) r_side[i] <= r_side[i-1];
            end
        end
        assign w_side_out = r_side[SLV_WS-1];
    end

    // ---------------- R buffer with registered head ----------------
    logic [RW-1:0]     r_r_mem [RD_DEPTH];
    logic [RDW-1:0]    r_r_wp, r_r_rp, w_r_rp_nxt;
    logic [CW-1:0]     r_r_cnt, w_r_cnt_nxt, w_r_keep;
    logic [RW-1:0]     w_r_wdata, w_r_head;
    logic              r_rvalid, r_rlast;
    logic [AXI_IW-1:0] r_rid;
    logic [AXI_DW-1:0] r_rdata;
    logic [1:0]        r_rresp;

    assign w_r_pop     = r_rvalid & axi.RREADY;
    assign w_r_wdata   = {w_side_out[SW-1:2], m_rdata, w_side_out[0] | m_rslverr, 1'b0,
                          w_side_out[1]};
    assign w_r_cnt_nxt = r_r_cnt + CW'(m_rvalid) - CW'(w_r_pop);
    assign w_r_rp_nxt  = r_r_rp + RDW'(w_r_pop);
    assign w_r_keep    = r_r_cnt - CW'(w_r_pop);
    assign w_r_head    = (w_r_keep == '0) ? w_r_wdata : r_r_mem[w_r_rp_nxt];

    always_ff @(posedge ACLK) begin
        if (m_rvalid) r_r_mem[r_r_wp] <= w_r_wdata;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_r_wp   <= '0;
            r_r_rp   <= '0;
            r_r_cnt  <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            if (m_rvalid) r_r_wp <= r_r_wp + RDW'(1);
            r_r_rp   <= w_r_rp_nxt;
            r_r_cnt  <= w_r_cnt_nxt;
            r_rvalid <= (w_r_cnt_nxt != '0);
            if (w_r_cnt_nxt != '0)
                {r_rid, r_rdata, r_rresp, r_rlast} <= w_r_head;
        end
    end

    assign axi.ARREADY = r_arready;
    assign axi.RVALID  = r_rvalid;
    assign axi.RID     = r_rid;
    assign axi.RDATA   = r_rdata;
    assign axi.RRESP   = r_rresp;
    assign axi.RLAST   = r_rlast;
endmodule

// File: tb/tb_asi_r_credit.sv
// Directed bench for asi_r_credit: burst address/response table plus credit,
// AR back-pressure and mid-burst reset sequences.
module tb_asi_r_credit;
    localparam int unsigned IW = 4, AW = 32, DW = 64, LW = 8;
    localparam int NV = 10;

    typedef struct packed {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [31:0]      inj;
        logic [3:0][31:0] exp_addr;
        logic [3:0][1:0]  exp_resp;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic        last;
        logic [31:0] cyc;
    } mre_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] cyc;
    } rb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    asi_r_credit_if #(.IW(IW), .AW(AW), .DW(DW), .LW(LW)) axi ();

    logic [IW-1:0] m_rid;
    logic [LW-1:0] m_rlen;
    logic [2:0]    m_rsize;
    logic [1:0]    m_rburst;
    logic [AW-1:0] m_raddr;
    logic          m_re, m_rlast;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid, m_rslverr;

    asi_r_credit #(.AXI_IW(IW), .AXI_AW(AW), .AXI_DW(DW), .AXI_LW(LW),
                   .OD_DEPTH(4), .RD_DEPTH(8), .SLV_WS(1)) dut (
        .ACLK(clk), .ARESET(rst), .axi(axi),
        .m_rid(m_rid), .m_rlen(m_rlen), .m_rsize(m_rsize), .m_rburst(m_rburst),
        .m_raddr(m_raddr), .m_re(m_re), .m_rlast(m_rlast),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rslverr(m_rslverr)
    );

    // User memory: one-cycle latency, data derived from the beat address.
    logic        inj_en;
    logic [31:0] inj_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rvalid  <= 1'b0;
            m_rdata   <= '0;
            m_rslverr <= 1'b0;
        end else begin
            m_rvalid  <= m_re;
            m_rdata   <= {~m_raddr, m_raddr};
            m_rslverr <= m_re && inj_en && (m_raddr == inj_addr);
        end
    end

    logic [31:0] cyc = 0;
    logic [31:0] ar_cyc = 0;
    mre_t mre_q[$];
    rb_t  r_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (m_re) mre_q.push_back('{m_rid, m_raddr, m_rlast, cyc});
        if (axi.RVALID && axi.RREADY)
            r_q.push_back('{axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, cyc});
        if (axi.ARVALID && axi.ARREADY) ar_cyc <= cyc + 1;
    end

    int n_err = 0, n_chk = 0;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs;
        int n;
        hs = 0; n = 0;
        axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size;
        axi.ARBURST = burst; axi.ARVALID = 1'b1;
        while (!hs && n < 64) begin
            @(negedge clk); hs = axi.ARREADY;
            @(posedge clk); n++;
        end
        #1 axi.ARVALID = 1'b0;
        chk($sformatf("ar handshake id%0h", id), 64'(hs), 64'd1);
    endtask

    task automatic wait_r(input int target, input int lim);
        int n;
        n = 0;
        while (r_q.size() < target && n < lim) begin
            @(posedge clk); #1; n++;
        end
        chk("r beats before timeout", 64'(r_q.size() >= target), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] inj, input logic [31:0] a0, a1, a2, a3,
                           input logic [1:0] r0, r1, r2, r3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.inj = inj;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        v.exp_resp[0] = r0; v.exp_resp[1] = r1; v.exp_resp[2] = r2; v.exp_resp[3] = r3;
        vec[i] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int mb, rb, nb;
        logic [31:0] a;
        bit found;
        int n;

        rst = 1'b1; inj_en = 1'b0; inj_addr = '0;
        axi.ARVALID = 1'b0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0;
        axi.ARSIZE = '0; axi.ARBURST = '0; axi.RREADY = 1'b1;

        //        i  id     addr          len size burst inj         beat addresses                                     resp
        set_vec(0, 4'h1, 32'h0000_1004, 3, 3, 2'b01, 0,            32'h1004, 32'h1008, 32'h1010, 32'h1018, 0, 0, 0, 0);
        set_vec(1, 4'h2, 32'h0000_1010, 3, 3, 2'b10, 0,            32'h1010, 32'h1018, 32'h1000, 32'h1008, 0, 0, 0, 0);
        set_vec(2, 4'h3, 32'h0000_1000, 2, 3, 2'b10, 0,            32'h1000, 32'h1008, 32'h1010, 0,        2, 2, 2, 0);
        set_vec(3, 4'h4, 32'h0000_2000, 1, 4, 2'b01, 0,            32'h2000, 32'h2010, 0,        0,        2, 2, 0, 0);
        set_vec(4, 4'h5, 32'h0000_3000, 3, 3, 2'b01, 32'h3010,     32'h3000, 32'h3008, 32'h3010, 32'h3018, 0, 0, 2, 0);
        set_vec(5, 4'h6, 32'h0000_4004, 2, 2, 2'b00, 0,            32'h4004, 32'h4004, 32'h4004, 0,        0, 0, 0, 0);
        set_vec(6, 4'h7, 32'h0000_501C, 1, 2, 2'b10, 0,            32'h501C, 32'h5018, 0,        0,        0, 0, 0, 0);
        set_vec(7, 4'h8, 32'hFFFF_FFFE, 3, 0, 2'b01, 0,            32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 0, 0, 0);
        set_vec(8, 4'h9, 32'h0000_0060, 0, 3, 2'b11, 0,            32'h0060, 0,        0,        0,        2, 0, 0, 0);
        set_vec(9, 4'hA, 32'h0000_7004, 1, 3, 2'b10, 0,            32'h7004, 32'h7008, 0,        0,        2, 2, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ARREADY", 64'(axi.ARREADY), 1);
        chk("reset RVALID", 64'(axi.RVALID), 0);
        chk("reset RLAST", 64'(axi.RLAST), 0);
        chk("reset RRESP", 64'(axi.RRESP), 0);
        chk("reset RID", 64'(axi.RID), 0);
        chk("reset RDATA", axi.RDATA, 0);
        chk("reset m_re", 64'(m_re), 0);
        chk("reset m_rlast", 64'(m_rlast), 0);
        chk("reset m_raddr", 64'(m_raddr), 0);
        chk("reset m_rid/len/size/burst", 64'({m_rid, m_rlen, m_rsize, m_rburst}), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Table of single bursts.
        for (int i = 0; i < NV; i++) begin
            mb = mre_q.size(); rb = r_q.size(); nb = int'(vec[i].len) + 1;
            inj_addr = vec[i].inj; inj_en = (vec[i].inj != 0);
            ar_send(vec[i].id, vec[i].addr, vec[i].len, vec[i].size, vec[i].burst);
            wait_r(rb + nb, 60);
            chk($sformatf("v%0d m_re count", i), 64'(mre_q.size() - mb), 64'(nb));
            chk($sformatf("v%0d R count", i), 64'(r_q.size() - rb), 64'(nb));
            if (mre_q.size() >= mb + nb && r_q.size() >= rb + nb) begin
                for (int b = 0; b < nb; b++) begin
                    a = vec[i].exp_addr[b];
                    chk($sformatf("v%0d b%0d m_raddr", i, b), 64'(mre_q[mb+b].addr), 64'(a));
                    chk($sformatf("v%0d b%0d m_rid", i, b), 64'(mre_q[mb+b].id), 64'(vec[i].id));
                    chk($sformatf("v%0d b%0d m_rlast", i, b), 64'(mre_q[mb+b].last), 64'(b == nb-1));
                    chk($sformatf("v%0d b%0d RID", i, b), 64'(r_q[rb+b].id), 64'(vec[i].id));
                    chk($sformatf("v%0d b%0d RDATA", i, b), r_q[rb+b].data, {~a, a});
                    chk($sformatf("v%0d b%0d RRESP", i, b), 64'(r_q[rb+b].resp), 64'(vec[i].exp_resp[b]));
                    chk($sformatf("v%0d b%0d RLAST", i, b), 64'(r_q[rb+b].last), 64'(b == nb-1));
                    if (i == 0 && b > 0) begin
                        chk($sformatf("v0 b%0d m_re back-to-back", b),
                            64'(mre_q[mb+b].cyc - mre_q[mb+b-1].cyc), 1);
                        chk($sformatf("v0 b%0d RVALID continuous", b),
                            64'(r_q[rb+b].cyc - r_q[rb+b-1].cyc), 1);
                    end
                end
                if (i == 0) begin
                    chk("latency AR to m_re", 64'(mre_q[mb].cyc - ar_cyc), 1);
                    chk("latency AR to RVALID", 64'(r_q[rb].cyc - ar_cyc), 3);
                end
            end
            inj_en = 1'b0;
        end

        // Credit stall: 16-beat burst against an 8-entry read buffer.
        axi.RREADY = 1'b0;
        mb = mre_q.size(); rb = r_q.size();
        ar_send(4'hC, 32'h8000, 15, 3, 2'b01);
        repeat (25) @(posedge clk);
        #1;
        chk("credit m_re while stalled", 64'(mre_q.size() - mb), 8);
        chk("credit RVALID held", 64'(axi.RVALID), 1);
        chk("credit no R handshake", 64'(r_q.size() - rb), 0);
        axi.RREADY = 1'b1;
        wait_r(rb + 16, 100);
        chk("credit m_re total", 64'(mre_q.size() - mb), 16);
        chk("credit R total", 64'(r_q.size() - rb), 16);
        if (r_q.size() >= rb + 16) begin
            for (int b = 0; b < 16; b++) begin
                a = 32'h8000 + 32'(b * 8);
                chk($sformatf("credit b%0d RDATA", b), r_q[rb+b].data, {~a, a});
                chk($sformatf("credit b%0d RLAST", b), 64'(r_q[rb+b].last), 64'(b == 15));
            end
        end

        // AR back-pressure: credit exhausted, then five single-beat reads.
        axi.RREADY = 1'b0;
        mb = mre_q.size(); rb = r_q.size();
        ar_send(4'hB, 32'hA000, 7, 3, 2'b01);
        repeat (12) @(posedge clk);
        #1;
        chk("bp first burst issued", 64'(mre_q.size() - mb), 8);
        for (int k = 1; k <= 4; k++) begin
            ar_send(4'(k), 32'hB000 + 32'(k * 8), 0, 3, 2'b01);
            @(negedge clk);
            chk($sformatf("bp ARREADY after AR %0d", k), 64'(axi.ARREADY), 64'(k < 4));
            @(posedge clk); #1;
        end
        axi.ARID = 4'd5; axi.ARADDR = 32'hB028; axi.ARLEN = 0; axi.ARSIZE = 3;
        axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp 5th AR blocked %0d", k), 64'(axi.ARREADY), 0);
        end
        @(posedge clk); #1 axi.RREADY = 1'b1;
        ar_send(4'd5, 32'hB028, 0, 3, 2'b01);
        wait_r(rb + 13, 100);
        chk("bp R total", 64'(r_q.size() - rb), 13);
        if (r_q.size() >= rb + 13) begin
            for (int b = 0; b < 13; b++) begin
                chk($sformatf("bp b%0d RID order", b), 64'(r_q[rb+b].id),
                    (b < 8) ? 64'hB : 64'(b - 7));
                chk($sformatf("bp b%0d RLAST", b), 64'(r_q[rb+b].last), 64'(b >= 7));
            end
        end

        // Reset while beat 2 of an 8-beat burst is on the user port.
        ar_send(4'hD, 32'h9000, 7, 3, 2'b01);
        found = 0; n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            found = (m_re && m_raddr == 32'h9010);
            n++;
        end
        chk("reset test beat 2 seen", 64'(found), 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset RVALID", 64'(axi.RVALID), 0);
        chk("async reset ARREADY", 64'(axi.ARREADY), 1);
        chk("async reset m_re", 64'(m_re), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post reset RVALID", 64'(axi.RVALID), 0);
        chk("post reset ARREADY", 64'(axi.ARREADY), 1);
        @(posedge clk); #1;
        mb = mre_q.size(); rb = r_q.size();
        ar_send(4'h3, 32'h9008, 0, 3, 2'b01);
        wait_r(rb + 1, 40);
        chk("post reset m_re count", 64'(mre_q.size() - mb), 1);
        chk("post reset R count", 64'(r_q.size() - rb), 1);
        if (r_q.size() >= rb + 1) begin
            a = 32'h9008;
            chk("post reset RID", 64'(r_q[rb].id), 3);
            chk("post reset RDATA", r_q[rb].data, {~a, a});
            chk("post reset RRESP", 64'(r_q[rb].resp), 0);
            chk("post reset RLAST", 64'(r_q[rb].last), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
